id_ex_pipe_reg: RTL

//  ID/EX pipeline register of the MIPS pipeline, with load-use and branch hazard detection.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/id_hazard_detect.sv | 56 +++++
 rtl/id_ex_pipe_reg.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit layout, pcSrc encodings, bubble constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Control bundle packing (MSB..LSB):
//   {ALUSrc, regWrite, memWrite, memRead, memtoReg, regDst, ALUOperation[1:0]}
package pipe_pkg;

    localparam int CTRL_W        = 8;

    // Bit positions inside the control bundle
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // Controller pcSrc encodings
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // A bubble is an all-zero control bundle: no write, no memory access.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // Named view of the control bundle; field order matches the bit indices above.
    typedef struct packed {
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage : pipe_pkg

// File: rtl/id_hazard_detect.sv
// Load-use and branch-operand hazard detection for the ID stage (purely combinational).
// Latency: 0 cycles, stall is a direct function of the inputs.
// Backpressure: none itself; stall is consumed by the pipeline register to freeze PC and IF/ID.
//
// Ports:
//   id_rs, id_rt        ID-stage source specifiers
//   id_isBranch         ID instruction is beq/bneq (operands compared in ID)
//   ex_memRead/RegWrite control bits of the instruction now in EX
//   ex_writeReg         destination of the instruction now in EX
//   mem_memRead         EX/MEM holds a load
//   mem_writeReg        destination of the instruction in EX/MEM
//   stall               any hazard present
module id_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_isBranch,
    input  logic             ex_memRead,
    input  logic             ex_regWrite,
    input  logic [REG_W-1:0] ex_writeReg,
    input  logic             mem_memRead,
    input  logic [REG_W-1:0] mem_writeReg,
    output logic             stall
);

    // $0 is hardwired to zero, so a write to it never produces a dependency.
    // rt is compared for every instruction, even when it is not a source;
    // that only costs an occasional spurious one-cycle stall.
    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt);
        return (r != '0) && ((r == rs) || (r == rt));
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic branch_ex;
    logic branch_mem;

    always_comb begin
        ex_hit     = reg_match(ex_writeReg, id_rs, id_rt);
        mem_hit    = reg_match(mem_writeReg, id_rs, id_rt);

        // Load result not available until after MEM.
        load_use   = ex_memRead && ex_hit;
        // Branches compare in ID, so any producer still in EX is too late.
        branch_ex  = id_isBranch && ex_regWrite && ex_hit;
        // A load one stage further on still has no data for the ID comparator.
        branch_mem = id_isBranch && mem_memRead && mem_hit;

        stall      = load_use || branch_ex || branch_mem;
    end

endmodule : id_hazard_detect

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble insertion, PC/IF-ID stall and IF/ID flush generation.
// Latency: 1 cycle from id_* to ex_*; hazard/flush outputs are combinational.
// Backpressure: a hazard freezes PC and IF/ID (pcWrite=ifidWrite=0) and loads a bubble into EX.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_ctrl/isBranch/pcSrc            decoded control from the ID controller
//   id_readData1/2, id_immExt         operands and sign-extended immediate
//   id_rs/rt/rd                       register specifiers
//   mem_memRead, mem_writeReg         load flag and destination of EX/MEM
//   ex_*                              registered bundle for the EX stage
//   pcWrite, ifidWrite, ifidFlush     front-end control
//   stall                             hazard indicator
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_isBranch,
    input  logic [1:0]        id_pcSrc,
    input  logic [DATA_W-1:0] id_readData1,
    input  logic [DATA_W-1:0] id_readData2,
    input  logic [DATA_W-1:0] id_immExt,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              mem_memRead,
    input  logic [REG_W-1:0]  mem_writeReg,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_readData1,
    output logic [DATA_W-1:0] ex_readData2,
    output logic [DATA_W-1:0] ex_immExt,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_writeReg,
    output logic              pcWrite,
    output logic              ifidWrite,
    output logic              ifidFlush,
    output logic              stall
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] read_data1;
        logic [DATA_W-1:0] read_data2;
        logic [DATA_W-1:0] imm_ext;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  write_reg;
    } ex_bundle_t;

    ex_bundle_t ex_q;
    ex_bundle_t ex_d;
    ex_bundle_t id_bundle;
    ctrl_t      id_ctrl_s;
    ctrl_t      ex_ctrl_s;
    logic       hz_stall;

    assign id_ctrl_s = ctrl_t'(id_ctrl);
    assign ex_ctrl_s = ctrl_t'(ex_q.ctrl);

    // Hazards are judged against what is registered in EX right now.
    id_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_isBranch  (id_isBranch),
        .ex_memRead   (ex_ctrl_s.mem_read),
        .ex_regWrite  (ex_ctrl_s.reg_write),
        .ex_writeReg  (ex_q.write_reg),
        .mem_memRead  (mem_memRead),
        .mem_writeReg (mem_writeReg),
        .stall        (hz_stall)
    );

    // Bundle as it would be captured with no hazard; destination selected by regDst.
    always_comb begin
        id_bundle            = '0;
        id_bundle.ctrl       = id_ctrl;
        id_bundle.read_data1 = id_readData1;
        id_bundle.read_data2 = id_readData2;
        id_bundle.imm_ext    = id_immExt;
        id_bundle.rs         = id_rs;
        id_bundle.rt         = id_rt;
        id_bundle.write_reg  = id_ctrl_s.reg_dst ? id_rd : id_rt;
    end

    // A stalled instruction stays in IF/ID and is replayed, so EX gets a bubble
    // rather than a duplicate. The bubble clears every field, not just control,
    // so nothing stale can leak into forwarding compares.
    always_comb begin
        ex_d = hz_stall ? ex_bundle_t'('0) : id_bundle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Reset overrides everything: front end frozen, no flush, no hazard reported.
    // During a stall pcSrc is ignored because the ID comparator may be reading
    // an operand that is not yet written back.
    always_comb begin
        stall     = !rst && hz_stall;
        pcWrite   = !rst && !hz_stall;
        ifidWrite = !rst && !hz_stall;
        ifidFlush = !rst && !hz_stall && (id_pcSrc != PCSRC_SEQ);
    end

    assign ex_ctrl      = ex_q.ctrl;
    assign ex_readData1 = ex_q.read_data1;
    assign ex_readData2 = ex_q.read_data2;
    assign ex_immExt    = ex_q.imm_ext;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_writeReg  = ex_q.write_reg;

endmodule : id_ex_pipe_reg
